game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_pkg.sv | 20 ++
 rtl/rise_detect.sv | 19 +
 rtl/game_state_ctrl.sv | 165 ++++++++++++++++
 tb/tb_game_state_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings and default tunables for the game state controller.
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    TITLE    = 3'd0,
    PLAY     = 3'd1,
    HIT      = 3'd2,
    GAMEOVER = 3'd3,
    PAUSE    = 3'd4
  } game_state_t;

  localparam int LIVES_INIT_DEF           = 3;
  localparam int TITLE_MIN_FRAMES_DEF     = 30;
  localparam int INVULN_FRAMES_DEF        = 120;
  localparam int GAMEOVER_HOLD_FRAMES_DEF = 180;
  localparam int BLINK_SHIFT_DEF          = 3;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; the history flop resets high so a level
// already asserted at reset release is not reported as a press.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic press
);

  logic din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b1;
    else        din_q <= din;
  end

  assign press = din & ~din_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: title, play, hit/invulnerability, game over.
// Optional pause support is built when GAME_PAUSE_EN is defined.
//
// state    | meaning
// TITLE    | title screen, waits for start press after minimum hold
// PLAY     | normal play, hits cost a life
// HIT      | post-hit invulnerability window, sprite blinks
// GAMEOVER | game-over screen, waits for restart press after hold
// PAUSE    | frozen play (GAME_PAUSE_EN builds only)
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT           = LIVES_INIT_DEF,
  parameter int TITLE_MIN_FRAMES     = TITLE_MIN_FRAMES_DEF,
  parameter int INVULN_FRAMES        = INVULN_FRAMES_DEF,
  parameter int GAMEOVER_HOLD_FRAMES = GAMEOVER_HOLD_FRAMES_DEF,
  parameter int BLINK_SHIFT          = BLINK_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btn_a,
  input  logic               btn_pause,
  input  logic               hit,
  output logic [STATE_W-1:0] state,
  output logic               play_en,
  output logic               invuln,
  output logic               blink,
  output logic [1:0]         lives,
  output logic               gameover,
  output logic               spawn_req,
  output logic               score_clr
);

  localparam logic [7:0] TITLE_MIN   = 8'(TITLE_MIN_FRAMES);
  localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);
  localparam logic [7:0] GO_HOLD     = 8'(GAMEOVER_HOLD_FRAMES);
  localparam logic [1:0] LIVES_LOAD  = 2'(LIVES_INIT);

  game_state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]  lives_q, lives_d;
  logic        spawn_d, clr_d;
  logic        press_a, press_pause, pause_req;

  rise_detect u_rise_a (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_a),
    .press (press_a)
  );

  rise_detect u_rise_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_pause),
    .press (press_pause)
  );

`ifdef GAME_PAUSE_EN
  game_state_t ret_q;
  assign pause_req = press_pause;

  // Remember where to resume; captured only on the cycle PAUSE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 ret_q <= PLAY;
    else if (state_d == PAUSE && state_q != PAUSE) ret_q <= state_q;
  end
`else
  logic unused_pause;
  assign pause_req    = 1'b0;
  assign unused_pause = press_pause;
`endif

  assign cnt_inc = (frame_tick && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    lives_d = lives_q;
    spawn_d = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      TITLE: begin
        if (press_a && cnt_q >= TITLE_MIN) begin
          state_d = PLAY;
          cnt_d   = 8'd0;
          lives_d = LIVES_LOAD;
          spawn_d = 1'b1;
          clr_d   = 1'b1;
        end
      end
      PLAY: begin
        // A hit outranks a simultaneous pause press.
        if (hit) begin
          cnt_d = 8'd0;
          if (lives_q > 2'd1) begin
            state_d = HIT;
            lives_d = lives_q - 2'd1;
            spawn_d = 1'b1;
          end else begin
            state_d = GAMEOVER;
            lives_d = 2'd0;
          end
        end else if (pause_req) begin
          state_d = PAUSE;
          cnt_d   = cnt_q;
        end
      end
      HIT: begin
        if (pause_req) begin
          state_d = PAUSE;
          cnt_d   = cnt_q;
        end else if (frame_tick && cnt_q == INVULN_LAST) begin
          state_d = PLAY;
          cnt_d   = 8'd0;
        end
      end
      GAMEOVER: begin
        if (press_a && cnt_q >= GO_HOLD) begin
          state_d = TITLE;
          cnt_d   = 8'd0;
        end
      end
`ifdef GAME_PAUSE_EN
      PAUSE: begin
        cnt_d = cnt_q;
        if (pause_req) state_d = ret_q;
      end
`endif
      default: begin
        state_d = TITLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TITLE;
      cnt_q     <= 8'd0;
      lives_q   <= 2'd0;
      play_en   <= 1'b0;
      invuln    <= 1'b0;
      blink     <= 1'b1;
      gameover  <= 1'b0;
      spawn_req <= 1'b0;
      score_clr <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lives_q   <= lives_d;
      play_en   <= (state_d == PLAY) || (state_d == HIT);
      invuln    <= (state_d == HIT) || (state_d == PAUSE && invuln);
      blink     <= (state_d == HIT) ? ~cnt_d[BLINK_SHIFT] : 1'b1;
      gameover  <= (state_d == GAMEOVER);
      spawn_req <= spawn_d;
      score_clr <= clr_d;
    end
  end

  assign state = state_q;
  assign lives = lives_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed self-checking bench for game_state_ctrl (default parameters).
module tb_game_state_ctrl;
  import game_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n, frame_tick, btn_a, btn_pause, hit;
  logic [STATE_W-1:0] state;
  logic               play_en, invuln, blink, gameover, spawn_req, score_clr;
  logic [1:0]         lives;
  logic [10:0]        obs, exp_v;
  int                 checks = 0;
  int                 errors = 0;

  game_state_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_a      (btn_a),
    .btn_pause  (btn_pause),
    .hit        (hit),
    .state      (state),
    .play_en    (play_en),
    .invuln     (invuln),
    .blink      (blink),
    .lives      (lives),
    .gameover   (gameover),
    .spawn_req  (spawn_req),
    .score_clr  (score_clr)
  );

  always #5 clk = ~clk;

  assign obs = {state, lives, play_en, invuln, blink, gameover, spawn_req, score_clr};

  function automatic logic [10:0] ev(input int s, l, p, i, b, g, sp, sc);
    return {3'(s), 2'(l), 1'(p), 1'(i), 1'(b), 1'(g), 1'(sp), 1'(sc)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_a = 1'b1; btn_pause = 1'b0; hit = 1'b0; frame_tick = 1'b0;
    step();
    step();
    exp_v = ev(0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_values got %h exp %h", obs, exp_v);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start_held();
    frames(40);
    exp_v = ev(0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL held_no_start got %h exp %h", obs, exp_v);
    end
    btn_a = 1'b0;
    step();
    btn_a = 1'b1;
    step();
    exp_v = ev(1, 3, 1, 0, 1, 0, 1, 1);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL start_play got %h exp %h", obs, exp_v);
    end
    btn_a = 1'b0;
    step();
    exp_v = ev(1, 3, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL start_pulse_one_cycle got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_title_min();
    frames(10);
    btn_a = 1'b1; step(); btn_a = 1'b0; step();
    exp_v = ev(0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL title_early_press got %h exp %h", obs, exp_v);
    end
    frames(19);
    btn_a = 1'b1; step(); btn_a = 1'b0; step();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL title_press_frame29 got %h exp %h", obs, exp_v);
    end
    frames(2);
    btn_a = 1'b1;
    step();
    btn_a = 1'b0;
    exp_v = ev(1, 3, 1, 0, 1, 0, 1, 1);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL title_press_frame31 got %h exp %h", obs, exp_v);
    end
    step();
  endtask

  task automatic test_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
    exp_v = ev(2, 2, 1, 1, 1, 0, 1, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL hit_enter got %h exp %h", obs, exp_v);
    end
    for (int f = 1; f < 120; f++) begin
      hit = 1'b1;
      frames(1);
      exp_v = ev(2, 2, 1, 1, (f[3] ? 0 : 1), 0, 0, 0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL hit_window_f%0d got %h exp %h", f, obs, exp_v);
      end
    end
    hit = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    exp_v = ev(1, 2, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL hit_exit_120 got %h exp %h", obs, exp_v);
    end
    step();
  endtask

  task automatic test_gameover();
    hit = 1'b1; step(); hit = 1'b0;
    exp_v = ev(2, 1, 1, 1, 1, 0, 1, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL second_hit got %h exp %h", obs, exp_v);
    end
    frames(120);
    exp_v = ev(1, 1, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL second_recover got %h exp %h", obs, exp_v);
    end
    hit = 1'b1; step(); hit = 1'b0;
    exp_v = ev(3, 0, 0, 0, 1, 1, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL third_hit_gameover got %h exp %h", obs, exp_v);
    end
    frames(100);
    btn_a = 1'b1; step(); btn_a = 1'b0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL gameover_press_100 got %h exp %h", obs, exp_v);
    end
    step();
    frames(80);
    btn_a = 1'b1; step(); btn_a = 1'b0;
    exp_v = ev(0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL gameover_press_180 got %h exp %h", obs, exp_v);
    end
    step();
  endtask

  task automatic test_hit_held();
    frames(30);
    btn_a = 1'b1; step(); btn_a = 1'b0;
    exp_v = ev(1, 3, 1, 0, 1, 0, 1, 1);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL restart_frame30 got %h exp %h", obs, exp_v);
    end
    hit = 1'b1;
    step();
    frames(119);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    exp_v = ev(1, 2, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL held_hit_play got %h exp %h", obs, exp_v);
    end
    step();
    hit = 1'b0;
    exp_v = ev(2, 1, 1, 1, 1, 0, 1, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL held_hit_extra_life got %h exp %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_hit();
    frames(10);
    exp_v = ev(2, 1, 1, 1, 0, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL mid_hit_blink got %h exp %h", obs, exp_v);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = ev(0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", obs, exp_v);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL after_reset got %h exp %h", obs, exp_v);
    end
  endtask

`ifdef GAME_PAUSE_EN
  task automatic test_pause();
    frames(30);
    btn_a = 1'b1; step(); btn_a = 1'b0; step();
    hit = 1'b1; step(); hit = 1'b0;
    frames(50);
    btn_pause = 1'b1; step(); btn_pause = 1'b0;
    exp_v = ev(4, 2, 0, 1, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL pause_enter got %h exp %h", obs, exp_v);
    end
    hit = 1'b1;
    frames(500);
    hit = 1'b0;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL pause_hold got %h exp %h", obs, exp_v);
    end
    btn_pause = 1'b1; step(); btn_pause = 1'b0;
    exp_v = ev(2, 2, 1, 1, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL unpause got %h exp %h", obs, exp_v);
    end
    step();
    frames(69);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL resume_69 got %h exp %h", obs, exp_v);
    end
    frames(1);
    exp_v = ev(1, 2, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL resume_70 got %h exp %h", obs, exp_v);
    end
    hit = 1'b1; btn_pause = 1'b1;
    step();
    hit = 1'b0; btn_pause = 1'b0;
    exp_v = ev(2, 1, 1, 1, 1, 0, 1, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL hit_beats_pause got %h exp %h", obs, exp_v);
    end
  endtask
`else
  task automatic test_no_pause();
    frames(30);
    btn_a = 1'b1; step(); btn_a = 1'b0; step();
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
    exp_v = ev(1, 3, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL pause_ignored got %h exp %h", obs, exp_v);
    end
    frames(5);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL pause_ignored_later got %h exp %h", obs, exp_v);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start_held();
    apply_reset();
    test_title_min();
    test_hit();
    test_gameover();
    test_hit_held();
    test_reset_mid_hit();
`ifdef GAME_PAUSE_EN
    test_pause();
`else
    test_no_pause();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
